// File: rtl/equation_checker.sv
// Equation-check engine: latch a target, collect X/Y/Z via Go, evaluate one of four equations, compare.
// Latency: 4 CALC cycles after Go falls in WAIT_Z, then COMPARE; correct/wrong visible two cycles after CALC3.
// No backpressure: Go/start/ack are level inputs sampled per state; one operand is loaded per Go press.
module equation_checker #(
    parameter int WIDTH     = 8,
    parameter int TIMER_W   = 7,
    parameter int MAX_TRIES = 3,
    parameter int TRY_W     = 2
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Go,
    input  logic               start,
    input  logic               ack,
    input  logic [1:0]         mode,
    input  logic [TIMER_W-1:0] OngoingTimer,
    input  logic [WIDTH-1:0]   DataIn,
    output logic [1:0]         load_sel,
    output logic               busy,
    output logic [WIDTH-1:0]   result,
    output logic [TRY_W-1:0]   tries_left,
    output logic               correct,
    output logic               wrong
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_LOAD_X   = 4'd1;
    localparam logic [3:0] S_WAIT_X   = 4'd2;
    localparam logic [3:0] S_LOAD_Y   = 4'd3;
    localparam logic [3:0] S_WAIT_Y   = 4'd4;
    localparam logic [3:0] S_LOAD_Z   = 4'd5;
    localparam logic [3:0] S_WAIT_Z   = 4'd6;
    localparam logic [3:0] S_CALC0    = 4'd7;
    localparam logic [3:0] S_CALC1    = 4'd8;
    localparam logic [3:0] S_CALC2    = 4'd9;
    localparam logic [3:0] S_CALC3    = 4'd10;
    localparam logic [3:0] S_COMPARE  = 4'd11;
    localparam logic [3:0] S_COMPLETE = 4'd12;
    localparam logic [3:0] S_FAIL     = 4'd13;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;

    localparam logic [1:0] DST_NONE = 2'd0;
    localparam logic [1:0] DST_X    = 2'd1;
    localparam logic [1:0] DST_Y    = 2'd2;
    localparam logic [1:0] DST_RES  = 2'd3;

    logic [3:0]       state;
    logic [1:0]       mode_r;
    logic [WIDTH-1:0] x, y, z, target;

    logic [1:0]       alu_op;
    logic [1:0]       alu_dst;
    logic [WIDTH-1:0] alu_a, alu_b, alu_out;

    // Per-mode micro-sequence for the shared ALU; x and y double as temporaries.
    always_comb begin
        alu_op  = OP_ADD;
        alu_a   = x;
        alu_b   = y;
        alu_dst = DST_NONE;
        case (state)
            S_CALC0: begin
                case (mode_r)
                    2'b00: begin alu_op = OP_MUL; alu_dst = DST_Y; end           // y = x*y
                    2'b01: begin alu_op = OP_MUL; alu_dst = DST_X; end           // x = x*y
                    2'b10: begin alu_op = OP_ADD; alu_dst = DST_X; end           // x = x+y
                    default: begin alu_op = OP_MUL; alu_b = x; alu_dst = DST_X; end // x = x*x
                endcase
            end
            S_CALC1: begin
                case (mode_r)
                    2'b00: begin alu_op = OP_MUL; alu_b = x; alu_dst = DST_X; end // x = x*x
                    2'b11: begin alu_op = OP_MUL; alu_a = y; alu_b = z; alu_dst = DST_Y; end // y = y*z
                    default: alu_dst = DST_NONE;
                endcase
            end
            S_CALC2: begin
                if (mode_r == 2'b00) begin
                    alu_op  = OP_MUL;                                             // x = x*x*z
                    alu_b   = z;
                    alu_dst = DST_X;
                end
            end
            S_CALC3: begin
                alu_dst = DST_RES;
                case (mode_r)
                    2'b00:   alu_op = OP_ADD;                                     // x*x*z + x*y
                    2'b01:   begin alu_op = OP_ADD; alu_b = z; end                // x*y + z
                    2'b10:   begin alu_op = OP_MUL; alu_b = z; end                // (x+y)*z
                    default: alu_op = OP_SUB;                                     // x*x - y*z
                endcase
            end
            default: alu_dst = DST_NONE;
        endcase
    end

    // Shared ALU, every result wraps modulo 2^WIDTH.
    always_comb begin
        case (alu_op)
            OP_SUB:  alu_out = alu_a - alu_b;
            OP_MUL:  alu_out = alu_a * alu_b;
            default: alu_out = alu_a + alu_b;
        endcase
    end

    // Control FSM, operand/target registers, retry counter and ALU write-back.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state      <= S_IDLE;
            mode_r     <= 2'b00;
            x          <= '0;
            y          <= '0;
            z          <= '0;
            target     <= '0;
            result     <= '0;
            tries_left <= TRY_W'(MAX_TRIES);
        end else begin
            case (alu_dst)
                DST_X:   x      <= alu_out;
                DST_Y:   y      <= alu_out;
                DST_RES: result <= alu_out;
                default: ;
            endcase
            case (state)
                S_IDLE: begin
                    if (start) begin
                        target     <= WIDTH'(OngoingTimer);
                        mode_r     <= mode;
                        tries_left <= TRY_W'(MAX_TRIES);
                        state      <= S_LOAD_X;
                    end
                end
                S_LOAD_X: if (Go)  begin x <= DataIn; state <= S_WAIT_X; end
                S_WAIT_X: if (!Go) state <= S_LOAD_Y;
                S_LOAD_Y: if (Go)  begin y <= DataIn; state <= S_WAIT_Y; end
                S_WAIT_Y: if (!Go) state <= S_LOAD_Z;
                S_LOAD_Z: if (Go)  begin z <= DataIn; state <= S_WAIT_Z; end
                S_WAIT_Z: if (!Go) state <= S_CALC0;
                S_CALC0:  state <= S_CALC1;
                S_CALC1:  state <= S_CALC2;
                S_CALC2:  state <= S_CALC3;
                S_CALC3:  state <= S_COMPARE;
                S_COMPARE: begin
                    if (result == target) begin
                        state <= S_COMPLETE;
                    end else if (tries_left == TRY_W'(1)) begin
                        tries_left <= '0;
                        state      <= S_FAIL;
                    end else begin
                        tries_left <= tries_left - TRY_W'(1);
                        state      <= S_LOAD_X;
                    end
                end
                S_COMPLETE, S_FAIL: if (ack) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Status outputs decoded purely from the state register.
    always_comb begin
        case (state)
            S_LOAD_X, S_WAIT_X: load_sel = 2'd1;
            S_LOAD_Y, S_WAIT_Y: load_sel = 2'd2;
            S_LOAD_Z, S_WAIT_Z: load_sel = 2'd3;
            default:            load_sel = 2'd0;
        endcase
        busy    = !((state == S_IDLE) || (state == S_COMPLETE) || (state == S_FAIL));
        correct = (state == S_COMPLETE);
        wrong   = (state == S_FAIL);
    end

endmodule

// File: tb/tb_equation_checker.sv
// Directed bench for equation_checker: retries, all four equations, Go hold, reset mid-compute.
// Checks are taken #1 after the rising edge; inputs are also changed there.
// Expected values are hand-computed from the equations modulo 256.
module tb_equation_checker;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Go, start, ack;
    logic [1:0] mode;
    logic [6:0] OngoingTimer;
    logic [7:0] DataIn;
    logic [1:0] load_sel;
    logic       busy;
    logic [7:0] result;
    logic [1:0] tries_left;
    logic       correct, wrong;

    int checks   = 0;
    int failures = 0;

    equation_checker #(.WIDTH(8), .TIMER_W(7), .MAX_TRIES(3), .TRY_W(2)) dut (
        .Clock(Clock), .Reset(Reset), .Go(Go), .start(start), .ack(ack),
        .mode(mode), .OngoingTimer(OngoingTimer), .DataIn(DataIn),
        .load_sel(load_sel), .busy(busy), .result(result),
        .tries_left(tries_left), .correct(correct), .wrong(wrong)
    );

    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One Go press: load on the first edge, release on the next.
    task automatic load_op(input logic [7:0] v);
        Go = 1'b1; DataIn = v; step();
        Go = 1'b0;             step();
    endtask

    // From LOAD_X, enter all three operands; returns with the FSM in CALC0.
    task automatic enter(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        load_op(a); load_op(b); load_op(c);
    endtask

    task automatic begin_eq(input logic [1:0] m, input logic [6:0] t);
        start = 1'b1; mode = m; OngoingTimer = t; step();
        start = 1'b0;
    endtask

    initial begin
        Reset = 1'b0; Go = 1'b0; start = 1'b0; ack = 1'b0;
        mode = 2'b00; OngoingTimer = '0; DataIn = '0;
        steps(2);
        check("rst_busy",     busy,       0);
        check("rst_result",   result,     0);
        check("rst_tries",    tries_left, 3);
        check("rst_correct",  correct,    0);
        check("rst_wrong",    wrong,      0);
        check("rst_load_sel", load_sel,   0);
        Reset = 1'b1;
        step();

        // Mode 00, target 25: two misses then a hit.
        begin_eq(2'b00, 7'd25);
        check("t1_load_sel_x", load_sel, 1);
        check("t1_busy",       busy,     1);
        enter(8'd2, 8'd3, 8'd4);
        steps(4);
        check("t1_res_22",    result, 8'd22);
        step();
        check("t1_wrong0",    wrong,      0);
        check("t1_retry_sel", load_sel,   1);
        check("t1_tries2",    tries_left, 2);
        enter(8'd3, 8'd1, 8'd2);
        steps(4);
        check("t1_res_21",    result, 8'd21);
        step();
        check("t1_tries1",    tries_left, 1);
        enter(8'd1, 8'd21, 8'd4);
        steps(4);
        check("t1_res_25",    result, 8'd25);
        check("t1_not_yet",   correct, 0);
        step();
        check("t1_correct",   correct,    1);
        check("t1_busy0",     busy,       0);
        check("t1_tries_kept", tries_left, 1);

        // start together with ack in COMPLETE: back to IDLE only.
        start = 1'b1; ack = 1'b1; step();
        start = 1'b0; ack = 1'b0;
        check("t6_correct0", correct,  0);
        check("t6_idle_sel", load_sel, 0);
        check("t6_idle_busy", busy,    0);

        // Mode 01, target 7: three misses exhaust the retries.
        begin_eq(2'b01, 7'd7);
        check("t2_tries3", tries_left, 3);
        enter(8'd5, 8'd6, 8'd3);
        steps(4);
        check("t2_res_33", result, 8'd33);
        step();
        check("t2_tries2", tries_left, 2);
        enter(8'd0, 8'd0, 8'd0);
        steps(5);
        check("t2_tries1", tries_left, 1);
        enter(8'd1, 8'd1, 8'd1);
        steps(5);
        check("t2_wrong",  wrong,      1);
        check("t2_tries0", tries_left, 0);
        check("t2_busy0",  busy,       0);
        start = 1'b1; step(); start = 1'b0;
        check("t2_start_ignored", wrong, 1);
        ack = 1'b1; step(); ack = 1'b0;
        check("t2_ack_wrong0", wrong, 0);
        check("t2_ack_busy0",  busy,  0);

        // Mode 11: 2*2 - 3*5 = -11 wraps to 0xF5.
        begin_eq(2'b11, 7'd0);
        enter(8'd2, 8'd3, 8'd5);
        steps(4);
        check("t3_res_f5", result, 8'hF5);
        Reset = 1'b0; step(); Reset = 1'b1;
        check("t3_reset_res", result, 0);

        // Mode 10: (200+100)*2 = 600 mod 256 = 0x58.
        begin_eq(2'b10, 7'd0);
        enter(8'd200, 8'd100, 8'd2);
        steps(4);
        check("t3_res_58", result, 8'h58);
        step();
        check("t3_retry_sel", load_sel, 1);

        // Hold Go for 10 cycles in LOAD_X: x loads once, later DataIn changes ignored.
        Go = 1'b1; DataIn = 8'd9; step();
        DataIn = 8'd50;
        steps(9);
        check("t4_parked", load_sel, 1);
        Go = 1'b0; step();
        check("t4_to_y", load_sel, 2);
        start = 1'b1; step(); start = 1'b0;
        check("t4_start_in_y", load_sel, 2);
        load_op(8'd1);
        load_op(8'd3);
        steps(4);
        check("t4_res_30", result, 8'd30);
        step();
        check("t4_tries1", tries_left, 1);

        // Reset asserted while in CALC2.
        enter(8'd1, 8'd1, 8'd1);
        steps(2);
        check("t5_busy_calc", busy, 1);
        Reset = 1'b0; step(); Reset = 1'b1;
        check("t5_busy0",    busy,       0);
        check("t5_result0",  result,     0);
        check("t5_correct0", correct,    0);
        check("t5_tries3",   tries_left, 3);
        check("t5_sel0",     load_sel,   0);
        step();
        check("t5_stay_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
